// File: rtl/bypass_net_param_pkg.sv
// Shared constants and helpers for the operand-bypass / load-use hazard unit.
// Pipeline stall-bus layout and default port/stage counts live here.
package bypass_net_param_pkg;

  localparam int unsigned StallW  = 6;
  localparam int unsigned StallId = 2;
  localparam int unsigned StallEx = 3;
  localparam logic        Stop    = 1'b1;
  localparam logic        NoStop  = 1'b0;

  localparam int unsigned FwdNumStg = 3;
  localparam int unsigned FwdNumRd  = 2;

  typedef enum logic [1:0] {
    RegLoad,
    RegHold,
    RegClear
  } reg_op_e;

  // ID stopped while EX advances means EX must receive a bubble.
  function automatic reg_op_e reg_op_f(logic flush, logic [StallW-1:0] stall);
    if (flush) begin
      return RegClear;
    end else if (stall[StallId] == Stop && stall[StallEx] == NoStop) begin
      return RegClear;
    end else if (stall[StallId] == NoStop) begin
      return RegLoad;
    end
    return RegHold;
  endfunction

endpackage

// File: rtl/bypass_net_param_if.sv
// Bus bundle between the ID stage and the bypass unit: source addresses,
// downstream writeback buses, pipeline control and the registered forward results.
interface bypass_net_param_if
  import bypass_net_param_pkg::*;
#(
  parameter int unsigned NUM_RD  = FwdNumRd,
  parameter int unsigned NUM_STG = FwdNumStg,
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned CNT_W   = 16
);

  logic                     i_flush;
  logic [StallW-1:0]        i_stall;
  logic [NUM_RD*AW-1:0]     i_rd_addr;
  logic [NUM_STG-1:0]       i_stg_we;
  logic [NUM_STG*AW-1:0]    i_stg_waddr;
  logic [NUM_STG*DW-1:0]    i_stg_wdata;
  logic [NUM_STG-1:0]       i_stg_ready;
  logic [NUM_RD-1:0]        o_fwd_sel_r;
  logic [NUM_RD*DW-1:0]     o_fwd_data_r;
  logic                     o_stall_for_load;
  logic [CNT_W-1:0]         o_ld_stall_cnt;

  modport master (
    output i_flush, i_stall, i_rd_addr, i_stg_we, i_stg_waddr, i_stg_wdata, i_stg_ready,
    input  o_fwd_sel_r, o_fwd_data_r, o_stall_for_load, o_ld_stall_cnt
  );

  modport slave (
    input  i_flush, i_stall, i_rd_addr, i_stg_we, i_stg_waddr, i_stg_wdata, i_stg_ready,
    output o_fwd_sel_r, o_fwd_data_r, o_stall_for_load, o_ld_stall_cnt
  );

endinterface

// File: rtl/bypass_port_sel.sv
// Per-read-port priority matcher: picks the youngest stage writing this source
// register and reports whether its result is still pending.
module bypass_port_sel #(
  parameter int unsigned NUM_STG = 3,
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 5
) (
  input  logic [AW-1:0]         i_rd_addr,
  input  logic [NUM_STG-1:0]    i_stg_we,
  input  logic [NUM_STG*AW-1:0] i_stg_waddr,
  input  logic [NUM_STG*DW-1:0] i_stg_wdata,
  input  logic [NUM_STG-1:0]    i_stg_ready,
  output logic                  o_sel,
  output logic [DW-1:0]         o_data,
  output logic                  o_hazard
);

  logic          w_hit;
  logic [DW-1:0] w_data;
  logic          w_hazard;

  // Walk oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    w_hit    = 1'b0;
    w_data   = '0;
    w_hazard = 1'b0;
    for (int s = int'(NUM_STG) - 1; s >= 0; s--) begin
      if (i_stg_we[s] && (i_stg_waddr[s*AW +: AW] == i_rd_addr) && (i_rd_addr != '0)) begin
        w_hit    = 1'b1;
        w_data   = i_stg_wdata[s*DW +: DW];
        w_hazard = ~i_stg_ready[s];
      end
    end
  end

  assign o_sel    = w_hit & ~w_hazard;
  assign o_data   = w_data;
  assign o_hazard = w_hazard;

endmodule

// File: rtl/bypass_net_param.sv
// Operand-bypass and load-use hazard unit between ID register-file reads and the
// ID/EX register: registered forward select/data plus a combinational load stall.
module bypass_net_param
  import bypass_net_param_pkg::*;
#(
  parameter int unsigned NUM_RD  = FwdNumRd,
  parameter int unsigned NUM_STG = FwdNumStg,
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned CNT_W   = 16
) (
  input logic               clk,
  input logic               rst,
  bypass_net_param_if.slave bus
);

  logic [NUM_RD-1:0]    w_sel;
  logic [NUM_RD*DW-1:0] w_data;
  logic [NUM_RD-1:0]    w_hazard;
  logic                 w_stall_for_load;
  reg_op_e              w_op;

  logic [NUM_RD-1:0]    r_fwd_sel;
  logic [NUM_RD*DW-1:0] r_fwd_data;
  logic [CNT_W-1:0]     r_ld_stall_cnt;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    bypass_port_sel #(
      .NUM_STG (NUM_STG),
      .DW      (DW),
      .AW      (AW)
    ) u_port_sel (
      .i_rd_addr   (bus.i_rd_addr[p*AW +: AW]),
      .i_stg_we    (bus.i_stg_we),
      .i_stg_waddr (bus.i_stg_waddr),
      .i_stg_wdata (bus.i_stg_wdata),
      .i_stg_ready (bus.i_stg_ready),
      .o_sel       (w_sel[p]),
      .o_data      (w_data[p*DW +: DW]),
      .o_hazard    (w_hazard[p])
    );
  end

  assign w_stall_for_load = |w_hazard;

  always_comb begin
    w_op = reg_op_f(bus.i_flush, bus.i_stall);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fwd_sel  <= '0;
      r_fwd_data <= '0;
    end else begin
      unique case (w_op)
        RegClear: begin
          r_fwd_sel  <= '0;
          r_fwd_data <= '0;
        end
        RegLoad: begin
          r_fwd_sel  <= w_sel;
          r_fwd_data <= w_data;
        end
        default: begin
          r_fwd_sel  <= r_fwd_sel;
          r_fwd_data <= r_fwd_data;
        end
      endcase
    end
  end

  // Saturating performance counter; flush deliberately does not gate it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ld_stall_cnt <= '0;
    end else if (w_stall_for_load && (r_ld_stall_cnt != {CNT_W{1'b1}})) begin
      r_ld_stall_cnt <= r_ld_stall_cnt + 1'b1;
    end
  end

  assign bus.o_fwd_sel_r      = r_fwd_sel;
  assign bus.o_fwd_data_r     = r_fwd_data;
  assign bus.o_stall_for_load = w_stall_for_load;
  assign bus.o_ld_stall_cnt   = r_ld_stall_cnt;

endmodule

// File: tb/tb_bypass_net_param.sv
// Directed bench for bypass_net_param: a 16-bit-counter instance and a 4-bit-counter
// instance share the same stimulus so counter saturation can be observed.
module tb_bypass_net_param;
  import bypass_net_param_pkg::*;

  localparam int unsigned NR = 2;
  localparam int unsigned NS = 3;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  bypass_net_param_if #(.NUM_RD(NR), .NUM_STG(NS), .DW(DW), .AW(AW), .CNT_W(16)) bus ();
  bypass_net_param_if #(.NUM_RD(NR), .NUM_STG(NS), .DW(DW), .AW(AW), .CNT_W(4))  bus4 ();

  bypass_net_param #(.NUM_RD(NR), .NUM_STG(NS), .DW(DW), .AW(AW), .CNT_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  bypass_net_param #(.NUM_RD(NR), .NUM_STG(NS), .DW(DW), .AW(AW), .CNT_W(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  assign bus4.i_flush     = bus.i_flush;
  assign bus4.i_stall     = bus.i_stall;
  assign bus4.i_rd_addr   = bus.i_rd_addr;
  assign bus4.i_stg_we    = bus.i_stg_we;
  assign bus4.i_stg_waddr = bus.i_stg_waddr;
  assign bus4.i_stg_wdata = bus.i_stg_wdata;
  assign bus4.i_stg_ready = bus.i_stg_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_stage(input int s, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input logic ready);
    bus.i_stg_we[s]             = we;
    bus.i_stg_waddr[s*AW +: AW] = addr;
    bus.i_stg_wdata[s*DW +: DW] = data;
    bus.i_stg_ready[s]          = ready;
  endtask

  task automatic clear_stages();
    for (int s = 0; s < int'(NS); s++) set_stage(s, 1'b0, '0, '0, 1'b1);
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] addr);
    bus.i_rd_addr[p*AW +: AW] = addr;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_flush = 1'b0;
    bus.i_stall = '0;
    bus.i_rd_addr = '0;
    clear_stages();
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (bus.o_fwd_sel_r !== 2'b00) begin
      errors++;
      $display("FAIL reset_sel got %b exp 00", bus.o_fwd_sel_r);
    end
    checks++;
    if (bus.o_fwd_data_r !== 64'h0) begin
      errors++;
      $display("FAIL reset_data got %h exp 0", bus.o_fwd_data_r);
    end
    checks++;
    if (bus.o_ld_stall_cnt !== 16'd0 || bus.o_stall_for_load !== 1'b0) begin
      errors++;
      $display("FAIL reset_cnt got cnt=%0d stall=%b exp 0/0", bus.o_ld_stall_cnt,
               bus.o_stall_for_load);
    end
  endtask

  task automatic test_priority();
    clear_stages();
    set_stage(0, 1'b1, 5'd8, 32'h11, 1'b1);
    set_stage(1, 1'b1, 5'd8, 32'h22, 1'b1);
    set_rd(0, 5'd8);
    set_rd(1, 5'd8);
    tick();
    checks++;
    if (bus.o_fwd_sel_r !== 2'b11) begin
      errors++;
      $display("FAIL prio_sel got %b exp 11", bus.o_fwd_sel_r);
    end
    checks++;
    if (bus.o_fwd_data_r !== {32'h11, 32'h11}) begin
      errors++;
      $display("FAIL prio_data got %h exp 0000001100000011", bus.o_fwd_data_r);
    end
  endtask

  task automatic test_zero_reg();
    clear_stages();
    set_stage(0, 1'b1, 5'd0, 32'hAA, 1'b0);
    set_stage(1, 1'b1, 5'd0, 32'hBB, 1'b1);
    set_stage(2, 1'b1, 5'd0, 32'hCC, 1'b1);
    set_rd(0, 5'd3);
    set_rd(1, 5'd0);
    #1;
    checks++;
    if (bus.o_stall_for_load !== 1'b0) begin
      errors++;
      $display("FAIL zero_stall got %b exp 0", bus.o_stall_for_load);
    end
    tick();
    checks++;
    if (bus.o_fwd_sel_r !== 2'b00 || bus.o_fwd_data_r !== 64'h0) begin
      errors++;
      $display("FAIL zero_out got sel=%b data=%h exp 00/0", bus.o_fwd_sel_r, bus.o_fwd_data_r);
    end
  endtask

  task automatic test_load_use();
    clear_stages();
    set_stage(0, 1'b1, 5'd9, 32'hDEAD, 1'b0);
    set_rd(0, 5'd9);
    set_rd(1, 5'd0);
    #1;
    checks++;
    if (bus.o_stall_for_load !== 1'b1) begin
      errors++;
      $display("FAIL lu_stall got %b exp 1", bus.o_stall_for_load);
    end
    tick();
    checks++;
    if (bus.o_ld_stall_cnt !== 16'd1 || bus.o_fwd_sel_r !== 2'b00 ||
        bus.o_fwd_data_r[DW-1:0] !== 32'hDEAD) begin
      errors++;
      $display("FAIL lu_first got cnt=%0d sel=%b d0=%h exp 1/00/dead", bus.o_ld_stall_cnt,
               bus.o_fwd_sel_r, bus.o_fwd_data_r[DW-1:0]);
    end
    tick();
    checks++;
    if (bus.o_ld_stall_cnt !== 16'd2) begin
      errors++;
      $display("FAIL lu_cnt2 got %0d exp 2", bus.o_ld_stall_cnt);
    end
    set_stage(0, 1'b0, 5'd0, 32'h0, 1'b1);
    set_stage(1, 1'b1, 5'd9, 32'h99, 1'b1);
    #1;
    checks++;
    if (bus.o_stall_for_load !== 1'b0) begin
      errors++;
      $display("FAIL lu_drop got %b exp 0", bus.o_stall_for_load);
    end
    tick();
    checks++;
    if (bus.o_fwd_sel_r !== 2'b01 || bus.o_fwd_data_r[DW-1:0] !== 32'h99 ||
        bus.o_ld_stall_cnt !== 16'd2) begin
      errors++;
      $display("FAIL lu_mem got sel=%b d0=%h cnt=%0d exp 01/99/2", bus.o_fwd_sel_r,
               bus.o_fwd_data_r[DW-1:0], bus.o_ld_stall_cnt);
    end
    // Younger pending load shadows an older ready producer.
    set_stage(0, 1'b1, 5'd9, 32'h77, 1'b0);
    #1;
    checks++;
    if (bus.o_stall_for_load !== 1'b1) begin
      errors++;
      $display("FAIL lu_young got %b exp 1", bus.o_stall_for_load);
    end
    tick();
    checks++;
    if (bus.o_ld_stall_cnt !== 16'd3 || bus.o_fwd_sel_r !== 2'b00) begin
      errors++;
      $display("FAIL lu_young_reg got cnt=%0d sel=%b exp 3/00", bus.o_ld_stall_cnt,
               bus.o_fwd_sel_r);
    end
  endtask

  task automatic test_stall();
    clear_stages();
    set_stage(0, 1'b1, 5'd8, 32'h11, 1'b1);
    set_rd(0, 5'd8);
    set_rd(1, 5'd0);
    bus.i_stall = 6'b000100;
    tick();
    checks++;
    if (bus.o_fwd_sel_r !== 2'b00 || bus.o_fwd_data_r !== 64'h0) begin
      errors++;
      $display("FAIL stall_bubble got sel=%b data=%h exp 00/0", bus.o_fwd_sel_r,
               bus.o_fwd_data_r);
    end
    bus.i_stall = '0;
    tick();
    checks++;
    if (bus.o_fwd_sel_r !== 2'b01 || bus.o_fwd_data_r[DW-1:0] !== 32'h11) begin
      errors++;
      $display("FAIL stall_load got sel=%b d0=%h exp 01/11", bus.o_fwd_sel_r,
               bus.o_fwd_data_r[DW-1:0]);
    end
    bus.i_stall = 6'b001100;
    set_stage(0, 1'b1, 5'd8, 32'h55, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.o_fwd_sel_r !== 2'b01 || bus.o_fwd_data_r[DW-1:0] !== 32'h11) begin
        errors++;
        $display("FAIL stall_hold%0d got sel=%b d0=%h exp 01/11", i, bus.o_fwd_sel_r,
                 bus.o_fwd_data_r[DW-1:0]);
      end
    end
    bus.i_stall = '0;
  endtask

  task automatic test_flush_reset();
    set_stage(0, 1'b1, 5'd8, 32'h33, 1'b1);
    tick();
    checks++;
    if (bus.o_fwd_data_r[DW-1:0] !== 32'h33) begin
      errors++;
      $display("FAIL flush_pre got %h exp 33", bus.o_fwd_data_r[DW-1:0]);
    end
    bus.i_flush = 1'b1;
    tick();
    checks++;
    if (bus.o_fwd_sel_r !== 2'b00 || bus.o_fwd_data_r !== 64'h0 ||
        bus.o_ld_stall_cnt !== 16'd3) begin
      errors++;
      $display("FAIL flush_clr got sel=%b data=%h cnt=%0d exp 00/0/3", bus.o_fwd_sel_r,
               bus.o_fwd_data_r, bus.o_ld_stall_cnt);
    end
    set_stage(0, 1'b1, 5'd8, 32'h33, 1'b0);
    tick();
    checks++;
    if (bus.o_ld_stall_cnt !== 16'd4) begin
      errors++;
      $display("FAIL flush_cnt got %0d exp 4", bus.o_ld_stall_cnt);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.o_stall_for_load !== 1'b1) begin
      errors++;
      $display("FAIL rst_stall got %b exp 1", bus.o_stall_for_load);
    end
    tick();
    checks++;
    if (bus.o_ld_stall_cnt !== 16'd0 || bus4.o_ld_stall_cnt !== 4'd0) begin
      errors++;
      $display("FAIL rst_cnt got %0d/%0d exp 0/0", bus.o_ld_stall_cnt, bus4.o_ld_stall_cnt);
    end
    bus.i_flush = 1'b0;
  endtask

  task automatic test_saturate();
    // Hazard on r8 still present from the previous task; release reset.
    rst = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14) begin
        checks++;
        if (bus4.o_ld_stall_cnt !== 4'd14) begin
          errors++;
          $display("FAIL sat_14 got %0d exp 14", bus4.o_ld_stall_cnt);
        end
      end
    end
    checks++;
    if (bus4.o_ld_stall_cnt !== 4'd15) begin
      errors++;
      $display("FAIL sat_cnt4 got %0d exp 15", bus4.o_ld_stall_cnt);
    end
    checks++;
    if (bus.o_ld_stall_cnt !== 16'd20) begin
      errors++;
      $display("FAIL sat_cnt16 got %0d exp 20", bus.o_ld_stall_cnt);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    test_reset();
    test_priority();
    test_zero_reg();
    test_load_use();
    test_stall();
    test_flush_reset();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
